// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI Quad Output Fast Read line reader.
package qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DESEL
  } qspi_state_t;

  localparam logic [7:0] CMD_QUAD_READ = 8'h6B;
  localparam int         CMD_BITS      = 8;
  localparam int         ADDR_BITS     = 24;
  localparam int         DUMMY_CYCLES  = 8;

  // Bit offset of nibble idx in a little-endian word when each byte arrives high nibble first.
  function automatic logic [4:0] nibble_lsb(input logic [2:0] idx);
    return {idx[2:1], ~idx[0], 2'b00};
  endfunction

endpackage

// File: rtl/qspi_sck_gen.sv
// SPI mode-0 clock divider: spi_sck toggles every CLK_DIV aclk cycles while enabled,
// with single-cycle flags marking the aclk edge that raises or lowers it.
module qspi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic en,
  output logic spi_sck,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          sck_q, sck_d;
  logic          terminal_s;

  assign terminal_s = (div_cnt_q == DIV_LAST);
  assign rise_tick  = en && terminal_s && !sck_q;
  assign fall_tick  = en && terminal_s && sck_q;
  assign spi_sck    = sck_q;

  // Divider next state; held low and cleared when disabled.
  always_comb begin
    div_cnt_d = div_cnt_q;
    sck_d     = sck_q;
    if (!en) begin
      div_cnt_d = {CW{1'b0}};
      sck_d     = 1'b0;
    end else if (terminal_s) begin
      div_cnt_d = {CW{1'b0}};
      sck_d     = ~sck_q;
    end else begin
      div_cnt_d = div_cnt_q + CW'(1);
      sck_d     = sck_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      div_cnt_q <= {CW{1'b0}};
      sck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
    end
  end

endmodule

// File: rtl/qspi_line_reader.sv
// Cache-line fetch over QSPI: issues Quad Output Fast Read (0x6B) per request and
// returns WORDS_PER_LINE little-endian 32-bit words, one qspi_dval strobe each.
module qspi_line_reader
  import qspi_pkg::*;
#(
  parameter int CLK_DIV        = 2,
  parameter int WORDS_PER_LINE = 4,
  parameter int CS_HIGH        = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [23:0] qspi_addr,
  input  logic        qspi_read_en,
  output logic [31:0] qspi_dout,
  output logic        qspi_dval,
  output logic        qspi_rready,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic [3:0]  spi_io_out,
  output logic [3:0]  spi_io_oe,
  input  logic [3:0]  spi_io_in
);

  localparam int             WCW       = $clog2(WORDS_PER_LINE + 1);
  localparam int             DCW       = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;
  localparam logic [5:0]     CMD_LEN   = 6'(CMD_BITS);
  localparam logic [5:0]     ADDR_LEN  = 6'(ADDR_BITS);
  localparam logic [5:0]     DUMMY_LEN = 6'(DUMMY_CYCLES);
  localparam logic [WCW-1:0] LINE_LEN  = WCW'(WORDS_PER_LINE);
  localparam logic [DCW-1:0] DESEL_END = DCW'(CS_HIGH - 1);
  localparam logic [3:0]     IO_OE_CMD = 4'b1101;

  qspi_state_t    state_q, state_d;
  logic [5:0]     bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [DCW-1:0] desel_cnt_q, desel_cnt_d;
  logic [39:0]    shreg_q, shreg_d;
  logic [31:0]    asm_q, asm_d;
  logic           rready_q, rready_d;
  logic           dval_q, dval_d;
  logic [31:0]    dout_q, dout_d;
  logic           cs_n_q, cs_n_d;
  logic [3:0]     io_out_q, io_out_d;
  logic [3:0]     io_oe_q, io_oe_d;

  logic           sck_en_s, rise_tick_s, fall_tick_s;
  logic [4:0]     nib_pos_s;

  assign sck_en_s  = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                     (state_q == ST_DUMMY) || (state_q == ST_DATA);
  assign nib_pos_s = nibble_lsb(bit_cnt_q[2:0]);

  qspi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .en        (sck_en_s),
    .spi_sck   (spi_sck),
    .rise_tick (rise_tick_s),
    .fall_tick (fall_tick_s)
  );

  // Next-state logic: counters step on rise ticks, outputs and phase changes on fall ticks.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    desel_cnt_d = desel_cnt_q;
    shreg_d     = shreg_q;
    asm_d       = asm_q;
    rready_d    = rready_q;
    dval_d      = 1'b0;
    dout_d      = dout_q;
    cs_n_d      = cs_n_q;
    io_out_d    = io_out_q;
    io_oe_d     = io_oe_q;

    case (state_q)
      ST_IDLE: begin
        if (qspi_read_en && rready_q) begin
          state_d   = ST_CMD;
          bit_cnt_d = 6'd0;
          // Command bit 7 goes straight to IO0; the register holds what follows.
          shreg_d   = {CMD_QUAD_READ[6:0], qspi_addr, 9'd0};
          rready_d  = 1'b0;
          cs_n_d    = 1'b0;
          io_out_d  = {2'b11, 1'b0, CMD_QUAD_READ[7]};
          io_oe_d   = IO_OE_CMD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CMD: begin
        if (rise_tick_s) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
        end else if (fall_tick_s) begin
          shreg_d     = {shreg_q[38:0], 1'b0};
          io_out_d[0] = shreg_q[39];
          if (bit_cnt_q == CMD_LEN) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 6'd0;
          end else begin
            state_d = ST_CMD;
          end
        end else begin
          state_d = ST_CMD;
        end
      end

      ST_ADDR: begin
        if (rise_tick_s) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
        end else if (fall_tick_s) begin
          if (bit_cnt_q == ADDR_LEN) begin
            state_d   = ST_DUMMY;
            bit_cnt_d = 6'd0;
            io_out_d  = 4'b0000;
            io_oe_d   = 4'b0000;
          end else begin
            shreg_d     = {shreg_q[38:0], 1'b0};
            io_out_d[0] = shreg_q[39];
          end
        end else begin
          state_d = ST_ADDR;
        end
      end

      ST_DUMMY: begin
        if (rise_tick_s) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
        end else if (fall_tick_s && (bit_cnt_q == DUMMY_LEN)) begin
          state_d    = ST_DATA;
          bit_cnt_d  = 6'd0;
          word_cnt_d = {WCW{1'b0}};
        end else begin
          state_d = ST_DUMMY;
        end
      end

      ST_DATA: begin
        if (rise_tick_s) begin
          asm_d[nib_pos_s +: 4] = spi_io_in;
          if (bit_cnt_q == 6'd7) begin
            dout_d     = asm_d;
            dval_d     = 1'b1;
            bit_cnt_d  = 6'd0;
            word_cnt_d = word_cnt_q + WCW'(1);
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end else if (fall_tick_s && (word_cnt_q == LINE_LEN)) begin
          state_d     = ST_DESEL;
          cs_n_d      = 1'b1;
          desel_cnt_d = {DCW{1'b0}};
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_DESEL: begin
        if (desel_cnt_q == DESEL_END) begin
          state_d  = ST_IDLE;
          rready_d = 1'b1;
        end else begin
          desel_cnt_d = desel_cnt_q + DCW'(1);
        end
      end

      default: begin
        state_d  = ST_IDLE;
        rready_d = 1'b1;
        cs_n_d   = 1'b1;
        io_out_d = 4'b0000;
        io_oe_d  = 4'b0000;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 6'd0;
      word_cnt_q  <= {WCW{1'b0}};
      desel_cnt_q <= {DCW{1'b0}};
      shreg_q     <= 40'd0;
      asm_q       <= 32'd0;
      rready_q    <= 1'b1;
      dval_q      <= 1'b0;
      dout_q      <= 32'd0;
      cs_n_q      <= 1'b1;
      io_out_q    <= 4'b0000;
      io_oe_q     <= 4'b0000;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      desel_cnt_q <= desel_cnt_d;
      shreg_q     <= shreg_d;
      asm_q       <= asm_d;
      rready_q    <= rready_d;
      dval_q      <= dval_d;
      dout_q      <= dout_d;
      cs_n_q      <= cs_n_d;
      io_out_q    <= io_out_d;
      io_oe_q     <= io_oe_d;
    end
  end

  assign qspi_rready = rready_q;
  assign qspi_dval   = dval_q;
  assign qspi_dout   = dout_q;
  assign spi_cs_n    = cs_n_q;
  assign spi_io_out  = io_out_q;
  assign spi_io_oe   = io_oe_q;

endmodule
